// File: rtl/craps_round_core_if.sv
// Craps scoring core bus: dice/roll request toward the core, score and
// display patterns back out to the board.
interface craps_round_core_if;
  logic       roll;
  logic [2:0] die0;
  logic [2:0] die1;
  logic [3:0] sum;
  logic [3:0] point;
  logic [1:0] result;
  logic       win;
  logic       loss;
  logic [6:0] disp1;
  logic [6:0] disp2;
  logic [6:0] disp5;
  logic [6:0] disp4;

  // Board side: drives roll and dice, observes score and displays.
  modport master (
    output roll, die0, die1,
    input  sum, point, result, win, loss, disp1, disp2, disp5, disp4
  );

  // Core side.
  modport slave (
    input  roll, die0, die1,
    output sum, point, result, win, loss, disp1, disp2, disp5, disp4
  );
endinterface

// File: rtl/craps_round_core.sv
// Two-dice craps round scorer: captures dice on each roll edge, applies the
// come-out / point rules and drives die and status 7-segment patterns.
module craps_round_core #(
  parameter logic [2:0] BLANK_CODE = 3'd7
) (
  input  logic              clock,
  input  logic              reset,
  craps_round_core_if.slave bus
);

  typedef enum logic [1:0] {
    RES_INIT   = 2'b00,
    RES_REROLL = 2'b01,
    RES_WIN    = 2'b10,
    RES_LOSE   = 2'b11
  } result_t;

  result_t    r_result;
  result_t    w_result_next;
  logic       r_roll_d;
  logic [2:0] r_code0;
  logic [2:0] r_code1;
  logic [3:0] r_sum;
  logic [3:0] r_point;
  logic [3:0] w_point_next;
  logic [3:0] w_sum;
  logic       w_event;
  logic       w_dice_ok;
  logic       w_accept;

  function automatic logic die_legal(input logic [2:0] d);
    return (d != 3'd0) && (d != 3'd7);
  endfunction

  function automatic logic [6:0] seg7(input logic [2:0] code);
    case (code)
      3'd0:    return 7'b1000000;
      3'd1:    return 7'b1111001;
      3'd2:    return 7'b0100100;
      3'd3:    return 7'b0110000;
      3'd4:    return 7'b0011001;
      3'd5:    return 7'b0010010;
      3'd6:    return 7'b0000010;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_sum     = {1'b0, bus.die0} + {1'b0, bus.die1};
  assign w_event   = bus.roll & ~r_roll_d;
  assign w_dice_ok = die_legal(bus.die0) && die_legal(bus.die1);
  assign w_accept  = w_event && w_dice_ok &&
                     ((r_result == RES_INIT) || (r_result == RES_REROLL));

  // Next result and point from the craps rules on an accepted roll.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_result_next = r_result;
    w_point_next  = r_point;
    if (w_accept) begin
      case (r_result)
        RES_INIT: begin
          if (w_sum == 4'd7 || w_sum == 4'd11)
            w_result_next = RES_WIN;
          else if (w_sum == 4'd2 || w_sum == 4'd3 || w_sum == 4'd12)
            w_result_next = RES_LOSE;
          else begin
            w_point_next  = w_sum;
            w_result_next = RES_REROLL;
          end
        end
        RES_REROLL: begin
          if (w_sum == r_point)
            w_result_next = RES_WIN;
          else if (w_sum == 4'd7)
            w_result_next = RES_LOSE;
        end
        default: ;
      endcase
    end
  end

  // State register: roll edge history, captured dice, sum, point, result.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_roll_d <= 1'b0;
      r_code0  <= BLANK_CODE;
      r_code1  <= BLANK_CODE;
      r_sum    <= 4'd0;
      r_point  <= 4'd0;
      r_result <= RES_INIT;
    end else begin
      r_roll_d <= bus.roll;
      r_result <= w_result_next;
      r_point  <= w_point_next;
      if (w_accept) begin
        r_code0 <= bus.die0;
        r_code1 <= bus.die1;
        r_sum   <= w_sum;
      end
    end
  end

  // Two-letter status display decoded from the result.
  always_comb begin
    bus.disp5 = 7'b1111111;
    bus.disp4 = 7'b1111111;
    case (r_result)
      RES_INIT:   begin bus.disp5 = 7'b0101111; bus.disp4 = 7'b0100011; end
      RES_REROLL: begin bus.disp5 = 7'b0101111; bus.disp4 = 7'b0101111; end
      RES_WIN:    begin bus.disp5 = 7'b1100011; bus.disp4 = 7'b1100011; end
      RES_LOSE:   begin bus.disp5 = 7'b1111001; bus.disp4 = 7'b0100011; end
      default: ;
    endcase
  end

  assign bus.sum    = r_sum;
  assign bus.point  = r_point;
  assign bus.result = r_result;
  assign bus.win    = (r_result == RES_WIN);
  assign bus.loss   = (r_result == RES_LOSE);
  assign bus.disp1  = seg7(r_code0);
  assign bus.disp2  = seg7(r_code1);

endmodule

// File: tb/tb_craps_round_core.sv
// Self-checking bench for craps_round_core: a reference model predicts the
// outputs for every driven cycle into a scoreboard queue that is popped and
// compared after the following rising edge.
module tb_craps_round_core;

  typedef struct packed {
    logic [3:0] sum;
    logic [3:0] point;
    logic [1:0] result;
    logic       win;
    logic       loss;
    logic [6:0] disp1;
    logic [6:0] disp2;
    logic [6:0] disp5;
    logic [6:0] disp4;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  obs_t sb[$];
  obs_t exp_v;
  obs_t got_v;

  // Reference model state.
  logic [2:0] m_code0, m_code1;
  logic [3:0] m_sum, m_point;
  logic [1:0] m_res;

  logic [6:0] seg_tbl [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111111};
  logic [6:0] st5_tbl [4] = '{7'b0101111, 7'b0101111, 7'b1100011, 7'b1111001};
  logic [6:0] st4_tbl [4] = '{7'b0100011, 7'b0101111, 7'b1100011, 7'b0100011};

  craps_round_core_if bus ();

  craps_round_core #(.BLANK_CODE(3'd7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t model_out();
    obs_t o;
    o.sum    = m_sum;
    o.point  = m_point;
    o.result = m_res;
    o.win    = (m_res == 2'b10);
    o.loss   = (m_res == 2'b11);
    o.disp1  = seg_tbl[m_code0];
    o.disp2  = seg_tbl[m_code1];
    o.disp5  = st5_tbl[m_res];
    o.disp4  = st4_tbl[m_res];
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{bus.sum, bus.point, bus.result, bus.win, bus.loss,
          bus.disp1, bus.disp2, bus.disp5, bus.disp4};
    return o;
  endfunction

  task automatic model_reset();
    m_code0 = 3'd7; m_code1 = 3'd7;
    m_sum = 4'd0; m_point = 4'd0; m_res = 2'b00;
  endtask

  task automatic model_roll(input logic [2:0] d0, input logic [2:0] d1);
    logic [3:0] s;
    if (d0 >= 3'd1 && d0 <= 3'd6 && d1 >= 3'd1 && d1 <= 3'd6 && m_res <= 2'b01) begin
      s = 4'(d0) + 4'(d1);
      m_code0 = d0; m_code1 = d1; m_sum = s;
      if (m_res == 2'b00) begin
        if (s == 7 || s == 11)              m_res = 2'b10;
        else if (s == 2 || s == 3 || s == 12) m_res = 2'b11;
        else begin m_point = s;             m_res = 2'b01; end
      end else begin
        if (s == m_point)                   m_res = 2'b10;
        else if (s == 7)                    m_res = 2'b11;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus.roll = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One roll pulse: roll low for a full clock, then high; predicted result is
  // queued and the task returns just after the capturing edge.
  task automatic do_roll(input logic [2:0] d0, input logic [2:0] d1);
    @(negedge clock);
    bus.roll = 1'b0;
    @(negedge clock);
    bus.die0 = d0; bus.die1 = d1; bus.roll = 1'b1;
    model_roll(d0, d1);
    sb.push_back(model_out());
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.roll = 1'b0; bus.die0 = 3'd1; bus.die1 = 3'd1;
    do_reset();
    sb.push_back(model_out());
    #1;
    exp_v = sb.pop_front(); got_v = sample(); n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL reset_state: got=%h expected=%h", got_v, exp_v);
    end
  endtask

  task automatic test_come_out_win();
    do_reset();
    do_roll(3'd3, 3'd4);
    exp_v = sb.pop_front(); got_v = sample(); n_checks++;
    if (got_v !== exp_v || got_v.result !== 2'b10) begin
      n_errors++;
      $display("FAIL come_out_win: got=%h expected=%h", got_v, exp_v);
    end
  endtask

  task automatic test_come_out_lose();
    logic [2:0] d [2][2] = '{'{3'd1, 3'd1}, '{3'd3, 3'd4}};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      do_roll(d[i][0], d[i][1]);
      exp_v = sb.pop_front(); got_v = sample(); n_checks++;
      if (got_v !== exp_v || got_v.loss !== 1'b1) begin
        n_errors++;
        $display("FAIL come_out_lose[%0d]: got=%h expected=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_point_win();
    logic [2:0] d [3][2] = '{'{3'd2, 3'd2}, '{3'd5, 3'd1}, '{3'd3, 3'd1}};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_roll(d[i][0], d[i][1]);
      exp_v = sb.pop_front(); got_v = sample(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL point_win[%0d]: got=%h expected=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_point_seven_out();
    logic [2:0] d [2][2] = '{'{3'd2, 3'd3}, '{3'd6, 3'd1}};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      do_roll(d[i][0], d[i][1]);
      exp_v = sb.pop_front(); got_v = sample(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL seven_out[%0d]: got=%h expected=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_hold_and_illegal();
    logic [2:0] bad [3][2] = '{'{3'd0, 3'd4}, '{3'd7, 3'd3}, '{3'd5, 3'd0}};
    do_reset();
    // Point 4 from the first cycle; later dice would change the score if taken.
    do_roll(3'd2, 3'd2);
    exp_v = sb.pop_front(); got_v = sample(); n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL hold_first: got=%h expected=%h", got_v, exp_v);
    end
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      bus.die0 = (i % 2 == 1) ? 3'd3 : 3'd6;
      bus.die1 = (i % 2 == 1) ? 3'd1 : 3'd1;
      sb.push_back(model_out());
      @(posedge clock);
      #1;
      exp_v = sb.pop_front(); got_v = sample(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL hold_cycle[%0d]: got=%h expected=%h", i, got_v, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_roll(bad[i][0], bad[i][1]);
      exp_v = sb.pop_front(); got_v = sample(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL illegal_die[%0d]: got=%h expected=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_with_roll();
    do_reset();
    do_roll(3'd2, 3'd3);
    void'(sb.pop_front());
    @(negedge clock);
    bus.roll = 1'b0;
    @(negedge clock);
    reset = 1'b1; bus.roll = 1'b1; bus.die0 = 3'd3; bus.die1 = 3'd4;
    model_reset();
    sb.push_back(model_out());
    @(posedge clock);
    #1;
    exp_v = sb.pop_front(); got_v = sample(); n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL reset_with_roll: got=%h expected=%h", got_v, exp_v);
    end
    @(negedge clock);
    reset = 1'b0; bus.roll = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] d0, d1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      d0 = 3'($urandom_range(0, 7));
      d1 = 3'($urandom_range(1, 6));
      do_roll(d0, d1);
      exp_v = sb.pop_front(); got_v = sample(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL random_roll[%0d] d=%0d,%0d: got=%h expected=%h",
                 i, d0, d1, got_v, exp_v);
      end
      if (m_res >= 2'b10 && ($urandom_range(0, 3) != 0)) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_come_out_win();
    test_come_out_lose();
    test_point_win();
    test_point_seven_out();
    test_hold_and_illegal();
    test_reset_with_roll();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
